// File: rtl/miner_pkg.sv
// Shared miner definitions: send FSM encoding,
// nonce queue defaults and counter widths.
package miner_pkg;

    localparam int DEPTH_DEF   = 8;
    localparam int TIMEOUT_DEF = 15;
    localparam int DROP_W      = 8;
    localparam int NONCE_W     = 32;

    typedef logic [NONCE_W-1:0] nonce_t;
    typedef logic [DROP_W-1:0]  drop_cnt_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    function automatic drop_cnt_t sat_inc(
        input drop_cnt_t v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/nonce_tx_queue_if.sv
// Serial transmitter handshake: one-cycle send
// request with a word, busy level back.
interface nonce_tx_queue_if;
    import miner_pkg::*;

    logic   tx_send;
    nonce_t tx_word;
    logic   tx_busy;

    modport master (
        output tx_send,
        output tx_word,
        input  tx_busy
    );

    modport slave (
        input  tx_send,
        input  tx_word,
        output tx_busy
    );

endinterface

// File: rtl/nonce_tx_queue_fifo.sv
// Nonce storage ring with wrapping pointers.
// Write at full is only issued alongside a pop.
module nonce_fifo
    import miner_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  nonce_t                   wr_data,
    input  logic                     rd_en,
    output nonce_t                   rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    nonce_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/nonce_tx_queue.sv
// Found-nonce capture from the hash domain, queueing
// and hand-off to the serial transmitter.
module nonce_tx_queue
    import miner_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
)
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    got_ticket,
    input  nonce_t                  golden_nonce,
    nonce_tx_queue_if.master        tx,
    output logic                    new_nonce,
    output logic [$clog2(DEPTH):0]  queue_count,
    output logic                    overflow,
    output drop_cnt_t               drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic      sync1;
    logic      sync2;
    logic      sync_prev;
    logic      cap_q;
    nonce_t    nonce_q;
    logic      full;
    logic      pop;
    logic      wr_en;
    logic      load;
    nonce_t    head;
    nonce_t    word_q;
    tx_state_t state;
    tx_state_t state_nx;
    logic [TW-1:0] wcnt;
    logic [TW-1:0] wcnt_nx;

    // Nonce is latched on the capture cycle; the write
    // lands one cycle later from registered copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            cap_q     <= 1'b0;
            nonce_q   <= '0;
        end else begin
            sync1     <= got_ticket;
            sync2     <= sync1;
            sync_prev <= sync2;
            cap_q     <= sync2 & ~sync_prev;
            if (sync2 & ~sync_prev) begin
                nonce_q <= golden_nonce;
            end
        end
    end

    assign full  = queue_count == (AW + 1)'(DEPTH);
    assign pop   = state == SEND;
    assign wr_en = cap_q & (~full | pop);

    nonce_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (nonce_q),
        .rd_en   (pop),
        .rd_data (head),
        .count   (queue_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            new_nonce  <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            new_nonce <= wr_en;
            if (cap_q & ~wr_en) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wcnt   <= '0;
            word_q <= '0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
            if (load) begin
                word_q <= head;
            end
        end
    end

    // The SEND cycle counts as the first timeout cycle.
    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (queue_count != '0 && !tx.tx_busy) begin
                    state_nx = SEND;
                    load     = 1'b1;
                end
            end
            SEND: begin
                state_nx = WAIT_BUSY;
                wcnt_nx  = TW'(1);
            end
            WAIT_BUSY: begin
                if (tx.tx_busy) begin
                    state_nx = WAIT_DONE;
                end else if (wcnt == TW'(TIMEOUT - 1)) begin
                    state_nx = IDLE;
                end else begin
                    wcnt_nx = wcnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx.tx_busy) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign tx.tx_send = state == SEND;
    assign tx.tx_word = word_q;

endmodule
